// File: rtl/alu_sequencer.sv
// -----------------------------------------------------------------------------
// alu_sequencer
//
// Multi-cycle controller that owns the accumulator (AC) and operand (R)
// registers around a combinational 16-bit ALU. It takes one command at a time
// over a valid/ready handshake and drives the ALU select while the command
// executes. The operation is repeated a programmable number of times, and each
// MUL pass holds the select for MUL_LAT cycles. Every pass writes the ALU
// result back into AC. Completion is signalled with a one-cycle done pulse.
//
// Parameters
//   MUL_LAT      cycles each MUL pass holds the select before capture (1..15)
//
// Ports
//   clk          rising-edge clock
//   rst_n        synchronous active-low reset
//   cmd_valid    command present
//   cmd_ready    sequencer idle and able to accept
//   cmd_op       ALU opcode (0 NOP .. B CLA, C-F pass R)
//   cmd_cnt      pass count, 0 treated as 1
//   cmd_operand  operand latched into R
//   alu_cs       ALU control select (NOP outside EXEC)
//   alu_acin     AC register driven to the ALU
//   alu_rin      R register driven to the ALU
//   alu_acout    ALU result (combinational)
//   ac_out       AC register
//   z_flag       zero flag of the last captured result
//   done         one-cycle completion pulse
//   busy         sequencer not idle
//
// Optional feature
//   ALU_SEQ_ZSTOP_EN  when defined, a zero result captured in EXEC ends the
//                     command immediately and clears the remaining passes.
// -----------------------------------------------------------------------------
module alu_sequencer #(
    parameter int MUL_LAT = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [3:0]  cmd_op,
    input  logic [3:0]  cmd_cnt,
    input  logic [15:0] cmd_operand,
    output logic [3:0]  alu_cs,
    output logic [15:0] alu_acin,
    output logic [15:0] alu_rin,
    input  logic [15:0] alu_acout,
    output logic [15:0] ac_out,
    output logic        z_flag,
    output logic        done,
    output logic        busy
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_MUL = 4'h7;

    // Last value of the MUL wait counter; capture happens on this count.
    localparam logic [3:0] WAIT_LAST = 4'(MUL_LAT - 1);

    logic [1:0]  state_reg,  state_next;
    logic [3:0]  op_reg,     op_next;
    logic [15:0] r_reg,      r_next;
    logic [15:0] ac_reg,     ac_next;
    logic        z_reg,      z_next;
    logic [3:0]  passes_reg, passes_next;
    logic [3:0]  wait_reg,   wait_next;

    logic        capture;
    logic        result_zero;

    // A non-MUL op captures every EXEC cycle; MUL only at the end of its wait.
    assign capture     = (state_reg == ST_EXEC) &&
                         ((op_reg != OP_MUL) || (wait_reg == WAIT_LAST));
    assign result_zero = (alu_acout == 16'h0000);

    always_comb begin
        state_next  = state_reg;
        op_next     = op_reg;
        r_next      = r_reg;
        ac_next     = ac_reg;
        z_next      = z_reg;
        passes_next = passes_reg;
        wait_next   = wait_reg;

        case (state_reg)
            ST_IDLE: begin
                if (cmd_valid) begin
                    op_next     = cmd_op;
                    r_next      = cmd_operand;
                    passes_next = (cmd_cnt == 4'd0) ? 4'd1 : cmd_cnt;
                    wait_next   = 4'd0;
                    state_next  = ST_EXEC;
                end
            end

            ST_EXEC: begin
                if (op_reg == OP_MUL) begin
                    wait_next = capture ? 4'd0 : wait_reg + 4'd1;
                end
                if (capture) begin
                    ac_next     = alu_acout;
                    z_next      = result_zero;
                    passes_next = passes_reg - 4'd1;
`ifdef ALU_SEQ_ZSTOP_EN
                    if (result_zero) begin
                        passes_next = 4'd0;
                        state_next  = ST_DONE;
                    end else if (passes_reg == 4'd1) begin
                        state_next = ST_DONE;
                    end
`else
                    if (passes_reg == 4'd1) begin
                        state_next = ST_DONE;
                    end
`endif
                end
            end

            ST_DONE: begin
                state_next = ST_IDLE;
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg  <= ST_IDLE;
            op_reg     <= OP_NOP;
            r_reg      <= 16'h0000;
            ac_reg     <= 16'h0000;
            z_reg      <= 1'b0;
            passes_reg <= 4'd0;
            wait_reg   <= 4'd0;
        end else begin
            state_reg  <= state_next;
            op_reg     <= op_next;
            r_reg      <= r_next;
            ac_reg     <= ac_next;
            z_reg      <= z_next;
            passes_reg <= passes_next;
            wait_reg   <= wait_next;
        end
    end

    // All control outputs decode registered state only.
    assign cmd_ready = (state_reg == ST_IDLE);
    assign busy      = (state_reg != ST_IDLE);
    assign done      = (state_reg == ST_DONE);
    assign alu_cs    = (state_reg == ST_EXEC) ? op_reg : OP_NOP;
    assign alu_acin  = ac_reg;
    assign alu_rin   = r_reg;
    assign ac_out    = ac_reg;
    assign z_flag    = z_reg;

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Multi-cycle controller that owns the accumulator (AC) and operand (R) registers around the combinational 16-bit ALU. It accepts one command at a time over a valid/ready handshake and drives the ALU control select each cycle. It repeats the operation a programmable number of times and holds the select for multiplies. It writes each ALU result back into AC and reports completion with a one-cycle `done` pulse and a registered zero flag. It sits between the instruction decode and the ALU, replacing direct decode-to-ALU wiring.

## Interface
- `MUL_LAT`, default 2: cycles each MUL pass holds the select before capture; legal range 1..15.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  synchronous active-low reset.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  sequencer can accept; equals (state==IDLE).
- `cmd_op`  in  4  ALU opcode: 0 NOP, 1 ADD, 2 SUB, 3 NOT, 4 AND, 5 OR, 6 XOR, 7 MUL, 8 SHR1, 9 SHR2, A MOV, B CLA; C–F pass R.
- `cmd_cnt`  in  4  pass count; 0 is treated as 1.
- `cmd_operand`  in  16  operand latched into R.
- `alu_cs`  out  4  ALU control select.
- `alu_acin`  out  16  AC register value driven to the ALU.
- `alu_rin`  out  16  R register value driven to the ALU.
- `alu_acout`  in  16  ALU result (combinational).
- `ac_out`  out  16  AC register.
- `z_flag`  out  1  registered zero flag of the last captured result.
- `done`  out  1  one-cycle completion pulse.
- `busy`  out  1  state≠IDLE.

## Operation
- States: IDLE, EXEC, DONE.
- **IDLE.** `alu_cs`=NOP.
  - On `cmd_valid`&&`cmd_ready` at a clock edge, latch op, R←`cmd_operand`, passes←max(`cmd_cnt`,1), wait←0, and go to EXEC.
- **EXEC.** `alu_cs`=latched op for every cycle in EXEC.
  - Non-MUL op: one pass per cycle.
  - MUL: one pass per `MUL_LAT` cycles. The wait counter runs 0..`MUL_LAT`-1 and capture occurs only when wait==`MUL_LAT`-1.
  - At capture: AC←`alu_acout`, `z_flag`←(`alu_acout`==16'h0000), passes←passes-1.
  - When passes reaches 0 at a capture, go to DONE.
- **DONE.** `done`=1 and `alu_cs`=NOP for one cycle, then return to IDLE.
- **Zero flag.** Computed internally from `alu_acout`; the ALU's own Z output is not used.
- **Arithmetic.** All arithmetic is mod 2^16 (ADD/SUB wrap, MUL keeps the low 16 bits). This is inherent to the ALU; the sequencer adds no extension.
- **No change outside capture.** AC, R and `z_flag` change only at capture or reset. `ac_out` tracks AC.
- **Commands while busy.** `cmd_valid` while busy is ignored, with no queueing. The requester must hold `cmd_valid` until it sees `cmd_ready`.
- **Reset.**
  - `rst_n` low at an edge forces state=IDLE, AC=0, R=0, `z_flag`=0, passes=0, wait=0, `done`=0, `busy`=0, `alu_cs`=NOP.
  - This applies in any state, including mid-EXEC. An aborted command never pulses `done`.
  - Commands presented while `rst_n` is low are not accepted.

## Timing
- Command accepted at edge E0.
- Non-MUL, n passes: EXEC cycles 1..n, captures at E1..En, `done` high in cycle n+1, `cmd_ready` high again in cycle n+2.
- MUL, n passes: EXEC spans n×`MUL_LAT` cycles, and `done` follows in the next cycle.
- Minimum command-to-command spacing is passes+2 cycles.
- `cmd_ready`, `busy` and `alu_cs` are decoded from registered state with no input-to-output combinational paths. The only combinational path is ALU→AC/`z_flag` capture.

## Configuration
- `ALU_SEQ_ZSTOP_EN` defined: in EXEC, a capture whose result is zero ends the command immediately. The sequencer goes to DONE regardless of remaining passes, and the passes register is cleared.
- `ALU_SEQ_ZSTOP_EN` undefined: all passes always execute; zero results only update `z_flag`.

## Test plan
- Release reset, then MOV operand 16'h1234, cnt 0 → `alu_cs`=A for 1 cycle, `ac_out`=16'h1234, `z_flag`=0, `done` 2 cycles after accept.
- AC=16'hFFFE, ADD operand 16'h0001, cnt 3:
  - Without `ALU_SEQ_ZSTOP_EN`: captures FFFF, 0000, 0001; final `ac_out`=16'h0001, `z_flag`=0, `done` at cycle 4.
  - With `ALU_SEQ_ZSTOP_EN`: `ac_out`=16'h0000, `z_flag`=1, `done` at cycle 3.
- AC=16'h0005, MUL operand 16'h0003, cnt 1, `MUL_LAT`=2 → `alu_cs`=7 for exactly 2 cycles, AC unchanged after the first, `ac_out`=16'h000F after the second, `done` at cycle 3.
- Second command held on `cmd_valid` during a SHR1 cnt 4 → `cmd_ready`=0 for cycles 1–5, second command accepted at the edge ending cycle 6, first command's `done` pulses exactly once.
- AC=16'h8000, SHR1 cnt 8, `rst_n` low at cycle 3 → next cycle IDLE, `ac_out`=0, `z_flag`=0, `alu_cs`=NOP, no `done` pulse.
- CLA (B) with AC=16'hABCD → `ac_out`=16'h0000, `z_flag`=1, `done` at cycle 2.
